// File: rtl/line_byte_sequencer.sv
// Critical-byte-first burst sequencer for a 16:1 line byte mux.
// Drives the mux select and registers the selected byte onto a valid/ready port.
module line_byte_sequencer #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [SEL_W-1:0]  req_offset,
    input  logic [SEL_W-1:0]  req_len,
    input  logic              abort,
    output logic [SEL_W-1:0]  mux_sel,
    input  logic [DATA_W-1:0] mux_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = SEL_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(2 ** SEL_W);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [SEL_W-1:0]  ptr, ptr_n;
    logic [CNT_W-1:0]  rem, rem_n;
    logic              ov, ov_n;
    logic [DATA_W-1:0] od, od_n;
    logic              ol, ol_n;
    logic              load;
    logic              take;

    // Next-state and datapath: load a byte whenever the output slot is
    // free or being drained, finish when the last byte is taken.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        rem_n   = rem;
        ov_n    = ov;
        od_n    = od;
        ol_n    = ol;
        take    = ov && out_ready;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    ptr_n   = req_offset;
                    rem_n   = (req_len == '0) ? FULL : {1'b0, req_len};
                    state_n = STREAM;
                end
            end
            STREAM: begin
                load = (rem != '0) && (!ov || out_ready);
                if (load) begin
                    od_n  = mux_byte;
                    ov_n  = 1'b1;
                    ol_n  = (rem == ONE);
                    ptr_n = ptr + 1'b1;
                    rem_n = rem - ONE;
                end else if (take) begin
                    ov_n    = 1'b0;
                    ol_n    = 1'b0;
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        // Cancel drops the burst outright; the held byte is discarded.
        if (abort && (state != IDLE)) begin
            state_n = IDLE;
            ptr_n   = ptr;
            rem_n   = '0;
            ov_n    = 1'b0;
            od_n    = od;
            ol_n    = 1'b0;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            rem   <= '0;
            ov    <= 1'b0;
            od    <= '0;
            ol    <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            rem   <= rem_n;
            ov    <= ov_n;
            od    <= od_n;
            ol    <= ol_n;
        end
    end

    assign mux_sel   = ptr;
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign out_valid = ov;
    assign out_data  = od;
    assign out_last  = ol;

endmodule

// File: tb/tb_line_byte_sequencer.sv
// Bench for line_byte_sequencer: queue-based burst model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_line_byte_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_offset = '0;
    logic [3:0] req_len = '0;
    logic       abort = 1'b0;
    logic [3:0] mux_sel;
    logic [7:0] mux_byte;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;
    logic       done;

    logic [7:0] line [16];

    int checks = 0;
    int errors = 0;
    bit armed = 1'b0;

    // Model: bytes still to be presented, plus the output slot.
    logic [3:0] q[$];
    bit         m_act = 1'b0;
    bit         m_done = 1'b0;
    bit         s_v = 1'b0;
    bit         s_last = 1'b0;
    logic [7:0] s_data = '0;
    int         accepts = 0;
    int         hs_cnt = 0;

    line_byte_sequencer #(.DATA_W(8), .SEL_W(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_offset(req_offset),
        .req_len(req_len),
        .abort(abort),
        .mux_sel(mux_sel),
        .mux_byte(mux_byte),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    assign mux_byte = line[mux_sel];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Burst model advanced on each rising edge.
    always @(posedge clk) begin
        int n;
        logic [3:0] sel;
        if (!rst_n) begin
            q.delete();
            m_act = 0; m_done = 0;
            s_v = 0; s_last = 0; s_data = '0;
        end else if ((m_act || m_done) && abort) begin
            q.delete();
            m_act = 0; m_done = 0;
            s_v = 0; s_last = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_act) begin
            if (req_valid) begin
                accepts++;
                n = (req_len == 0) ? 16 : int'(req_len);
                for (int i = 0; i < n; i++)
                    q.push_back(4'((int'(req_offset) + i) % 16));
                m_act = 1;
            end
        end else begin
            if (s_v && out_ready) hs_cnt++;
            if (s_v && out_ready && q.size() == 0) begin
                s_v = 0; s_last = 0;
                m_act = 0; m_done = 1;
            end else if (q.size() != 0 && (!s_v || out_ready)) begin
                sel = q.pop_front();
                s_data = line[sel];
                s_v = 1;
                s_last = (q.size() == 0);
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (armed) begin
            chk("req_ready", req_ready, !(m_act || m_done));
            chk("busy", busy, m_act || m_done);
            chk("done", done, m_done);
            chk("out_valid", out_valid, s_v);
            chk("out_last", out_last, s_last);
            if (s_v) chk("out_data", out_data, s_data);
            if (m_act && q.size() != 0) chk("mux_sel", mux_sel, q[0]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!req_ready && n < 100) begin
            cyc();
            n++;
        end
        chk("idle_timeout", req_ready, 1);
    endtask

    task automatic issue(input logic [3:0] off, input logic [3:0] len);
        req_offset = off;
        req_len = len;
        req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
    endtask

    initial begin
        int base;
        int n;
        for (int i = 0; i < 16; i++) line[i] = 8'hA0 + 8'(i);
        cyc();
        cyc();
        armed = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_mux_sel", mux_sel, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Full line from offset 0.
        wait_idle();
        issue(4'd0, 4'd0);
        repeat (2) @(negedge clk);
        chk("t1_first", out_data, 8'hA0);
        chk("t1_first_last", out_last, 0);
        repeat (15) @(negedge clk);
        chk("t1_final", out_data, 8'hAF);
        chk("t1_final_last", out_last, 1);
        @(negedge clk);
        chk("t1_done", done, 1);
        @(negedge clk);
        chk("t1_ready", req_ready, 1);
        chk("t1_done_once", done, 0);
        cyc();

        // Wrap from offset 14.
        wait_idle();
        base = hs_cnt;
        issue(4'd14, 4'd4);
        @(negedge clk);
        repeat (2) @(negedge clk);
        chk("t2_wrap_sel", mux_sel, 0);
        chk("t2_byte2", out_data, 8'hAF);
        repeat (2) @(negedge clk);
        chk("t2_byte4", out_data, 8'hA1);
        chk("t2_last", out_last, 1);
        cyc();
        wait_idle();
        chk("t2_handshakes", hs_cnt - base, 4);

        // Backpressure on the first byte.
        issue(4'd5, 4'd3);
        out_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_stall_data", out_data, 8'hA5);
            chk("t3_stall_valid", out_valid, 1);
        end
        cyc();
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("t3_a7", out_data, 8'hA7);
        chk("t3_a7_last", out_last, 1);
        @(negedge clk);
        chk("t3_done", done, 1);
        cyc();

        // Abort on the third output cycle.
        wait_idle();
        issue(4'd0, 4'd8);
        repeat (3) cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        @(negedge clk);
        chk("t4_valid", out_valid, 0);
        chk("t4_ready", req_ready, 1);
        @(negedge clk);
        chk("t4_no_done", done, 0);
        cyc();
        issue(4'd11, 4'd5);
        repeat (2) @(negedge clk);
        chk("t4_new_first", out_data, 8'hAB);
        cyc();
        wait_idle();

        // Reset mid-burst, then a request held across a busy burst.
        issue(4'd2, 4'd10);
        repeat (3) cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_valid", out_valid, 0);
        chk("t5_data", out_data, 0);
        chk("t5_busy", busy, 0);
        chk("t5_sel", mux_sel, 0);
        chk("t5_done", done, 0);
        cyc();
        issue(4'd3, 4'd6);
        req_offset = 4'd12;
        req_len = 4'd2;
        req_valid = 1'b1;
        base = accepts;
        n = 0;
        while (accepts == base && n < 60) begin
            cyc();
            n++;
        end
        req_valid = 1'b0;
        chk("t5_held_accepts", accepts - base, 1);
        wait_idle();

        // Single byte.
        issue(4'd9, 4'd1);
        repeat (2) @(negedge clk);
        chk("t6_data", out_data, 8'hA9);
        chk("t6_last", out_last, 1);
        @(negedge clk);
        chk("t6_done", done, 1);
        cyc();
        wait_idle();

        // Random traffic against the model.
        for (int i = 0; i < 16; i++) line[i] = 8'($urandom);
        for (int c = 0; c < 3000; c++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_offset = 4'($urandom);
            req_len = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            abort = ($urandom_range(0, 39) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
            cyc();
        end
        rst_n = 1'b1;
        abort = 1'b0;
        req_valid = 1'b0;
        out_ready = 1'b1;
        cyc();
        wait_idle();
        repeat (2) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/line_byte_sequencer.md
Name: line_byte_sequencer

Overview:
- Controller that sequences the 16:1 byte-select mux over a 16-byte cache line. It streams a programmable burst of bytes out on a valid/ready byte port.
- Bursts are critical-byte-first: they start at a given byte offset and wrap modulo 16.
- Sits between the data-array line output (muxed by the byte mux) and the core-side read return path. It drives the mux select and captures the mux output into a one-entry output register.

Parameters:
- DATA_W, 8, byte width of the mux output and the stream port.
- SEL_W, 4, select width; line holds 2**SEL_W bytes (16).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- req_valid  input  1  burst request.
- req_ready  output  1  high only in IDLE; request accepted when req_valid && req_ready.
- req_offset  input  SEL_W  starting byte index within the line.
- req_len  input  SEL_W  burst length in bytes; 0 encodes 16, otherwise 1..15.
- abort  input  1  cancel current burst.
- mux_sel  output  SEL_W  select to byte mux (combinational from internal pointer).
- mux_byte  input  DATA_W  byte mux output, valid in the same cycle as mux_sel.
- out_valid  output  1  output register holds a byte.
- out_ready  input  1  consumer accepts byte.
- out_data  output  DATA_W  registered byte.
- out_last  output  1  qualifies final byte of burst.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse after final byte handshake.

Behaviour:
- Reset (rst_n=0 at an edge), from any state: state=IDLE, ptr=0, remaining=0, out_valid=0, out_data=0, out_last=0, done=0. Hence req_ready=1, busy=0, mux_sel=0. Reset mid-burst discards the burst; no done pulse.
- Internal state: ptr (SEL_W bits) and remaining (SEL_W+1 bits). mux_sel = ptr at all times.
- FSM states are IDLE, STREAM and DONE.
  - IDLE: on accept, ptr <= req_offset; remaining <= (req_len==0) ? 16 : req_len; go to STREAM. req_valid while not in IDLE is ignored; there is no queueing.
  - STREAM, load condition: remaining!=0 && (!out_valid || out_ready). On load, out_data <= mux_byte, out_valid <= 1, out_last <= (remaining==1), ptr <= ptr+1 mod 16 (15 wraps to 0), remaining <= remaining-1.
  - STREAM, handshake with remaining==0 (last byte taken): out_valid <= 0, out_last <= 0, go to DONE.
  - STREAM, handshake with remaining!=0: the load above occurs in the same cycle, so there is no bubble.
  - STREAM, backpressure: while out_valid && !out_ready, out_data, out_last and ptr hold stable.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency: request accepted in cycle T; first out_valid in T+2. With out_ready held high, one byte per cycle. For an N-byte burst, done is asserted in T+N+2 and req_ready is high again in T+N+3.
- abort: when busy and abort=1, go to IDLE next cycle. out_valid, out_last and remaining are cleared, and no done pulse is generated. abort in IDLE has no effect. Reset has priority over abort.
- mux_byte is sampled only on load cycles. Any other value presented on it is don't-care.

Test Plan:
- Mux model returns 0xA0+sel. Offset 0, len 0, out_ready=1, accept at T -> out_data A0..AF on cycles T+2..T+17; out_last only with AF; done at T+18; req_ready at T+19.
- Offset 14, len 4 -> bytes AE, AF, A0, A1; mux_sel wraps 15->0; out_last with A1; exactly 4 handshakes.
- Offset 5, len 3, out_ready low for cycles T+2..T+4 -> out_data=A5 stable with out_valid=1 throughout the stall; then A6, A7 back-to-back; done one cycle after the A7 handshake.
- Offset 0, len 8, abort at the 3rd output cycle -> IDLE next cycle, out_valid=0, no done, req_ready=1. A new request then streams correctly from its own offset.
- rst_n=0 for one cycle mid-burst (offset 2, len 10) -> all outputs at reset values next cycle, no done. A request with req_valid held during busy is ignored and is accepted only once IDLE.
- Offset 9, len 1 -> single byte A9 with out_last=1 at T+2; done at T+3.
